fp16_addsub_unit: RTL and testbench
===================================

# fp16_addsub_unit

Single-precision-slot FPU front end for binary16 (IEEE 754 half) addition/subtraction. It uses the FPU's standard operand, opcode and handshake interface and produces one rounded result per accepted operation. It has a single output register stage. It sits between the issue logic and the writeback arbiter, and is the FP16-only instance of the top-level FPU interface.

## Interface
Clock and reset: one clock; reset is synchronous and active-low (`clk_i`, `rst_ni`).

Parameters:
- `WIDTH`, default 16: operand/result width; only 16 is supported.
- `NUM_OPERANDS`, default 3: number of operand slots.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `operands_i` in [3][16]: operand slots. ADD uses slot 1 (a) and slot 2 (b); slot 0 is ignored.
- `rnd_mode_i` in 3: `roundmode_e` (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4).
- `op_i` in 4: `operation_e`; only ADD is supported.
- `op_mod_i` in 1: 0 computes a+b; 1 computes a−b.
- `src_fmt_i`, `dst_fmt_i` in 3: `fp_format_e`; must be FP16.
- `int_fmt_i` in 2, `vectorial_op_i` in 1, `simd_mask_i` in 2: ignored.
- `tag_i` in 1: opaque tag, returned with the result.
- `in_valid_i` in 1 / `in_ready_o` out 1: input handshake.
- `out_valid_o` out 1 / `out_ready_i` in 1: output handshake.
- `flush_i` in 1: synchronous pipeline clear.
- `result_o` out 16: result.
- `status_o` out 5: `status_t` {NV,DZ,OF,UF,NX}.
- `tag_o` out 1: tag of the current result.
- `busy_o` out 1: unit holds a result.

## Operation
- Effective b is b with its sign inverted when `op_mod_i`=1.
- Supported rounding modes: RNE, RTZ, RDN, RUP, RMM. Rounding uses guard/round/sticky bits. Subnormal inputs and outputs are fully supported.
- Exact zero sum of opposite-sign operands gives +0, except −0 under RDN. The sum of two zeros of equal sign keeps that sign.
- NaN handling:
  - Any NaN input returns canonical NaN 0x7E00.
  - A signalling NaN input sets NV.
  - inf + (−inf) returns 0x7E00 and sets NV.
- Infinity handling: infinity plus a finite value returns that infinity with no flags.
- Overflow sets OF and NX. The result is ±inf, or ±0x7BFF when the rounding mode rounds toward zero for that sign (RTZ; RDN for positive results; RUP for negative results).
- NX is set whenever the rounded result differs from the exact sum.
- UF is always 0, because a binary16 sum below the normal range is exact. DZ is always 0.
- Unsupported requests return 0x7E00 with NV set: `op_i`≠ADD, or `src_fmt_i`/`dst_fmt_i`≠FP16, or `rnd_mode_i`>4.

## Timing
- A transfer is accepted on a rising edge where `in_valid_i && in_ready_o`. The result, status and tag are registered on that edge.
- `out_valid_o` rises the following cycle, so latency is 1 cycle.
- `in_ready_o = !out_valid_o || out_ready_i`. This allows back-to-back issue at full throughput while the consumer is ready.
- A result is retired on an edge where `out_valid_o && out_ready_i`. When a new acceptance happens on the same edge, the new result replaces the old one and `out_valid_o` stays high.
- While `out_ready_i`=0, `result_o`, `status_o` and `tag_o` hold stable.
- `busy_o = out_valid_o`.
- `flush_i`=1 on an edge clears `out_valid_o`, and any input presented in that cycle is dropped. `in_ready_o` remains 1 during flush.
- Reset values: `out_valid_o`=0, `busy_o`=0, `result_o`=0, `status_o`=0, `tag_o`=0. Reset overrides an operation in flight.

## Structure
- Shared package `fpnew_pkg` defines `roundmode_e`, `operation_e`, `fp_format_e`, `int_format_e`, `status_t` and the FP16 constants (bias 15, canonical NaN 0x7E00).
- Sub-module `fp16_add_core`: purely combinational. It takes a, b, op_mod and rnd_mode and returns result and status.
- The top level adds request validation, the output register, the handshake logic and the tag.

## Test plan
- 0x3C00 + 0x3C00 with ADD, `op_mod_i`=0, RNE → 0x4000, status 00000, `out_valid_o` one cycle after acceptance.
- 0x4200 with `op_mod_i`=1 and 0x4000, RNE → 0x3C00, status 00000.
- 0x7C00 with `op_mod_i`=1 and 0x7C00 → 0x7E00, NV=1. 0x7D00 (sNaN) + 0x3C00 → 0x7E00, NV=1.
- Overflow:
  - 0x7BFF + 0x7BFF, RNE → 0x7C00, OF=NX=1.
  - Same operands, RTZ → 0x7BFF, OF=NX=1.
- Rounding and signed zero:
  - 0x3C00 + 0x0001: RNE → 0x3C00 with NX=1; RUP → 0x3C01.
  - 0x3C00 − 0x3C00 under RDN → 0x8000.
- Handshake and flush:
  - Hold `out_ready_i`=0 → `in_ready_o`=0 and the result is stable. Releasing `out_ready_i` retires the result and allows a new issue on the same edge.
  - Asserting `flush_i` with a valid result → `out_valid_o`=0 on the next cycle.
  - Reset mid-operation clears all outputs.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU types and binary16 constants for the FP16 add/sub front end.
// Combinational helpers only; no latency, no flow control.
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  localparam int          FP16_BIAS    = 15;
  localparam int          FP16_EXP_MAX = 2 * FP16_BIAS + 1;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;

  // Leading-zero count of a 14-bit field; returns 14 for an all-zero input.
  function automatic logic [3:0] clz14(input logic [13:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(13 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_add_core.sv
// Combinational binary16 adder: align, add/subtract, normalise, round (G/R/S).
// Zero latency; no flow control.
module fp16_add_core
  import fpnew_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        op_mod_i,
  input  logic [2:0]  rnd_mode_i,
  output logic [15:0] result_o,
  output logic [4:0]  status_o
);

  logic [15:0] b_eff;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic [15:0] x, y;
  logic [4:0]  ex_x, ex_y, d;
  logic [10:0] mx, my;
  logic [40:0] y_full;
  logic [13:0] x_al, y_al;
  logic        eff_sub;
  logic [14:0] sum;
  logic [3:0]  lz;
  logic [4:0]  sh, sh_lim;
  logic [13:0] m;
  logic [5:0]  e6;
  logic        up, inexact, ovf, tz;
  logic [15:0] rounded;
  logic [15:0] res;
  status_t     st;

  assign b_eff  = {b_i[15] ^ op_mod_i, b_i[14:0]};
  assign a_nan  = (&a_i[14:10]) & (|a_i[9:0]);
  assign b_nan  = (&b_i[14:10]) & (|b_i[9:0]);
  assign a_snan = a_nan & ~a_i[9];
  assign b_snan = b_nan & ~b_i[9];
  assign a_inf  = (&a_i[14:10]) & ~(|a_i[9:0]);
  assign b_inf  = (&b_i[14:10]) & ~(|b_i[9:0]);

  // x carries the larger magnitude so the aligned difference never goes negative.
  assign x    = (a_i[14:0] >= b_eff[14:0]) ? a_i : b_eff;
  assign y    = (a_i[14:0] >= b_eff[14:0]) ? b_eff : a_i;
  assign ex_x = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
  assign ex_y = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
  assign mx   = {|x[14:10], x[9:0]};
  assign my   = {|y[14:10], y[9:0]};
  assign d    = ex_x - ex_y;

  assign y_full  = {my, 30'd0} >> d;
  assign y_al    = {y_full[40:28], |y_full[27:0]};
  assign x_al    = {mx, 3'b000};
  assign eff_sub = x[15] ^ y[15];
  assign sum     = eff_sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});

  // Left shift stops at exponent 1 so small results fall into the subnormal range.
  assign lz     = clz14(sum[13:0]);
  assign sh_lim = ex_x - 5'd1;
  assign sh     = ({1'b0, lz} < sh_lim) ? {1'b0, lz} : sh_lim;

  always_comb begin
    m  = '0;
    e6 = '0;
    if (sum[14]) begin
      m  = {sum[14:2], |sum[1:0]};
      e6 = {1'b0, ex_x} + 6'd1;
    end else begin
      m  = sum[13:0] << sh;
      e6 = m[13] ? ({1'b0, ex_x} - {1'b0, sh}) : 6'd0;
    end
  end

  assign inexact = |m[2:0];

  always_comb begin
    up = 1'b0;
    case (rnd_mode_i)
      RNE:     up = m[2] & ((|m[1:0]) | m[3]);
      RTZ:     up = 1'b0;
      RDN:     up = x[15] & inexact;
      RUP:     up = ~x[15] & inexact;
      RMM:     up = m[2];
      default: up = 1'b0;
    endcase
  end

  // Incrementing the packed {exp, frac} lets mantissa carries ripple into the exponent.
  assign rounded = {e6, m[12:3]} + {15'd0, up};
  assign ovf     = rounded[15:10] >= 6'(FP16_EXP_MAX);
  assign tz      = (rnd_mode_i == RTZ) | ((rnd_mode_i == RDN) & ~x[15]) |
                   ((rnd_mode_i == RUP) & x[15]);

  always_comb begin
    res = '0;
    st  = '0;
    if (a_nan || b_nan) begin
      res   = FP16_QNAN;
      st.nv = a_snan | b_snan;
    end else if (a_inf && b_inf && (a_i[15] != b_eff[15])) begin
      res   = FP16_QNAN;
      st.nv = 1'b1;
    end else if (a_inf) begin
      res = a_i;
    end else if (b_inf) begin
      res = b_eff;
    end else if (sum == 15'd0) begin
      res = {eff_sub ? (rnd_mode_i == RDN) : x[15], 15'd0};
    end else if (ovf) begin
      res   = {x[15], tz ? 15'h7BFF : 15'h7C00};
      st.of = 1'b1;
      st.nx = 1'b1;
    end else begin
      res   = {x[15], rounded[14:0]};
      st.nx = inexact;
    end
  end

  assign result_o = res;
  assign status_o = st;

endmodule

// File: rtl/fp16_addsub_unit.sv
// FP16 add/sub FPU slot: request validation plus a single output register stage.
// Latency 1 cycle; in_ready_o drops only while a held result is not being taken.
module fp16_addsub_unit
  import fpnew_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0]   operands_i,
  input  logic [2:0]                           rnd_mode_i,
  input  logic [3:0]                           op_i,
  input  logic                                 op_mod_i,
  input  logic [2:0]                           src_fmt_i,
  input  logic [2:0]                           dst_fmt_i,
  input  logic [1:0]                           int_fmt_i,
  input  logic                                 vectorial_op_i,
  input  logic [1:0]                           simd_mask_i,
  input  logic                                 tag_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 flush_i,
  output logic [WIDTH-1:0]                     result_o,
  output logic [4:0]                           status_o,
  output logic                                 tag_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  localparam status_t STATUS_INVALID = '{nv: 1'b1, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};

  logic        valid_q, valid_d;
  logic [15:0] result_q, result_d;
  logic [4:0]  status_q, status_d;
  logic        tag_q, tag_d;
  logic [15:0] core_res;
  logic [4:0]  core_st;
  logic        req_ok, accept;
  logic        unused_inputs;

  assign unused_inputs = ^{operands_i[0], int_fmt_i, vectorial_op_i, simd_mask_i};

  fp16_add_core u_core (
    .a_i        (operands_i[1]),
    .b_i        (operands_i[2]),
    .op_mod_i   (op_mod_i),
    .rnd_mode_i (rnd_mode_i),
    .result_o   (core_res),
    .status_o   (core_st)
  );

  assign req_ok = (op_i == ADD) && (src_fmt_i == FP16) && (dst_fmt_i == FP16) &&
                  (rnd_mode_i <= 3'd4);

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    status_d = status_q;
    tag_d    = tag_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = req_ok ? core_res : FP16_QNAN;
      status_d = req_ok ? core_st : STATUS_INVALID;
      tag_d    = tag_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      tag_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      status_q <= status_d;
      tag_q    <= tag_d;
    end
  end

  assign out_valid_o = valid_q;
  assign busy_o      = valid_q;
  assign result_o    = result_q;
  assign status_o    = status_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_fp16_addsub_unit.sv
// Scoreboard bench for fp16_addsub_unit: directed corner cases, handshake/flush/reset, random traffic.
module tb_fp16_addsub_unit;
  import fpnew_pkg::*;

  logic             clk_i;
  logic             rst_ni;
  logic [2:0][15:0] operands_i;
  logic [2:0]       rnd_mode_i;
  logic [3:0]       op_i;
  logic             op_mod_i;
  logic [2:0]       src_fmt_i, dst_fmt_i;
  logic [1:0]       int_fmt_i;
  logic             vectorial_op_i;
  logic [1:0]       simd_mask_i;
  logic             tag_i, in_valid_i, in_ready_o, flush_i;
  logic [15:0]      result_o;
  logic [4:0]       status_o;
  logic             tag_o, out_valid_o, out_ready_i, busy_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] sb[$];
  logic        rdy_rand = 1'b0;
  int          tag_ctr = 0;

  fp16_addsub_unit #(.WIDTH(16), .NUM_OPERANDS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .operands_i(operands_i), .rnd_mode_i(rnd_mode_i),
    .op_i(op_i), .op_mod_i(op_mod_i), .src_fmt_i(src_fmt_i), .dst_fmt_i(dst_fmt_i),
    .int_fmt_i(int_fmt_i), .vectorial_op_i(vectorial_op_i), .simd_mask_i(simd_mask_i),
    .tag_i(tag_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real mag;
    if (h[14:10] == 5'd0) mag = real'(int'(h[9:0])) * pow2(-24);
    else mag = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -mag : mag;
  endfunction

  // Reference for finite operands: exact sum in double precision, then rounded onto the FP16 grid.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic md, input logic [2:0] rm);
    logic [15:0] be;
    real x, ax, q, n, lo, fr, mag;
    logic sgn, up, toward;
    int e;
    longint li, bits;
    be = {b[15] ^ md, b[14:0]};
    x  = h2r(a) + h2r(be);
    if (x == 0.0) begin
      if (a[14:0] == 15'd0 && be[14:0] == 15'd0 && a[15] == be[15]) return {5'b0, a[15], 15'd0};
      return {5'b0, (rm == 3'd2), 15'd0};
    end
    sgn = (x < 0.0);
    ax  = sgn ? -x : x;
    if (ax < pow2(-14)) q = pow2(-24);
    else begin
      e = -14;
      while (ax >= pow2(e + 1)) e++;
      q = pow2(e - 10);
    end
    n  = ax / q;
    lo = $floor(n);
    fr = n - lo;
    li = longint'(lo);
    case (rm)
      3'd0:    up = (fr > 0.5) || (fr == 0.5 && li[0]);
      3'd2:    up = sgn && (fr > 0.0);
      3'd3:    up = !sgn && (fr > 0.0);
      3'd4:    up = (fr >= 0.5);
      default: up = 1'b0;
    endcase
    mag = (lo + (up ? 1.0 : 0.0)) * q;
    if (mag >= 65536.0) begin
      toward = (rm == 3'd1) || (rm == 3'd2 && !sgn) || (rm == 3'd3 && sgn);
      return {5'b00101, sgn, toward ? 15'h7BFF : 15'h7C00};
    end
    if (mag < pow2(-14)) bits = longint'(mag / pow2(-24));
    else begin
      e = -14;
      while (mag >= pow2(e + 1)) e++;
      bits = (longint'(e + 15) << 10) | (longint'(mag / pow2(e - 10)) - 1024);
    end
    return {4'b0000, fr > 0.0, sgn, bits[14:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called one tick after a rising edge; returns one tick after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic md,
                       input logic [2:0] rm, input logic [3:0] op, input logic [2:0] fmt,
                       input logic [15:0] er, input logic [4:0] es);
    int   tries;
    logic done;
    tries = 0;
    done  = 1'b0;
    operands_i = {b, a, 16'hDEAD};
    op_mod_i   = md;
    rnd_mode_i = rm;
    op_i       = op;
    src_fmt_i  = fmt;
    dst_fmt_i  = fmt;
    tag_i      = tag_ctr[0];
    in_valid_i = 1'b1;
    while (!done) begin
      if (rdy_rand) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (in_ready_o) begin
        sb.push_back({tag_i, es, er});
        done = 1'b1;
      end else if (++tries > 200) begin
        chk("issue_timeout", 32'(tries), 32'd0);
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    tag_ctr++;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i && !flush_i) begin
      if (sb.size() == 0) chk("unexpected_output", 32'(sb.size()), 32'd1);
      else chk("result", 32'({tag_o, status_o, result_o}), 32'(sb.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rm_d;
    logic [2:0]  rr;
    logic [20:0] mexp;
    rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    operands_i = '0; rnd_mode_i = 3'd0; op_i = ADD; op_mod_i = 1'b0;
    src_fmt_i = FP16; dst_fmt_i = FP16; int_fmt_i = 2'd0; vectorial_op_i = 1'b0;
    simd_mask_i = 2'd0; tag_i = 1'b0;

    idle(3);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_status", 32'(status_o), 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    rst_ni = 1'b1;
    idle(1);
    chk("idle_in_ready", 32'(in_ready_o), 32'd1);

    chk("pre_issue_valid", 32'(out_valid_o), 32'd0);
    issue(16'h3C00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h4000, 5'h00);
    chk("latency_valid", 32'(out_valid_o), 32'd1);
    issue(16'h4200, 16'h4000, 1'b1, RNE, ADD, FP16, 16'h3C00, 5'h00);
    issue(16'h7C00, 16'h7C00, 1'b1, RNE, ADD, FP16, 16'h7E00, 5'h10);
    issue(16'h7D00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h7E00, 5'h10);
    issue(16'h7E00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h7E00, 5'h00);
    issue(16'h7BFF, 16'h7BFF, 1'b0, RNE, ADD, FP16, 16'h7C00, 5'h05);
    issue(16'h7BFF, 16'h7BFF, 1'b0, RTZ, ADD, FP16, 16'h7BFF, 5'h05);
    issue(16'hFBFF, 16'hFBFF, 1'b0, RDN, ADD, FP16, 16'hFC00, 5'h05);
    issue(16'hFBFF, 16'hFBFF, 1'b0, RUP, ADD, FP16, 16'hFBFF, 5'h05);
    issue(16'h3C00, 16'h0001, 1'b0, RNE, ADD, FP16, 16'h3C00, 5'h01);
    issue(16'h3C00, 16'h0001, 1'b0, RUP, ADD, FP16, 16'h3C01, 5'h01);
    issue(16'h3C00, 16'h1000, 1'b0, RNE, ADD, FP16, 16'h3C00, 5'h01);
    issue(16'h3C00, 16'h1000, 1'b0, RMM, ADD, FP16, 16'h3C01, 5'h01);
    issue(16'h3C00, 16'h3C00, 1'b1, RDN, ADD, FP16, 16'h8000, 5'h00);
    issue(16'h3C00, 16'h3C00, 1'b1, RNE, ADD, FP16, 16'h0000, 5'h00);
    issue(16'h8000, 16'h8000, 1'b0, RNE, ADD, FP16, 16'h8000, 5'h00);
    issue(16'h0000, 16'h0000, 1'b1, RNE, ADD, FP16, 16'h0000, 5'h00);
    issue(16'h0001, 16'h0001, 1'b0, RNE, ADD, FP16, 16'h0002, 5'h00);
    issue(16'h0400, 16'h0001, 1'b1, RNE, ADD, FP16, 16'h03FF, 5'h00);
    issue(16'h3C01, 16'h3C00, 1'b1, RNE, ADD, FP16, 16'h1400, 5'h00);
    issue(16'hFC00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'hFC00, 5'h00);
    issue(16'h3C00, 16'h3C00, 1'b0, RNE, MUL, FP16, 16'h7E00, 5'h10);
    issue(16'h3C00, 16'h3C00, 1'b0, RNE, ADD, FP32, 16'h7E00, 5'h10);
    issue(16'h3C00, 16'h3C00, 1'b0, 3'd5, ADD, FP16, 16'h7E00, 5'h10);
    idle(2);

    // Stall: result must hold while the consumer is not ready.
    out_ready_i = 1'b0;
    issue(16'h3C00, 16'h4000, 1'b0, RNE, ADD, FP16, 16'h4200, 5'h00);
    chk("stall_in_ready", 32'(in_ready_o), 32'd0);
    idle(3);
    chk("stall_valid", 32'(out_valid_o), 32'd1);
    chk("stall_hold", 32'({tag_o, status_o, result_o}), 32'(sb[0]));
    out_ready_i = 1'b1;
    issue(16'h4400, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h4500, 5'h00);
    chk("b2b_valid", 32'(out_valid_o), 32'd1);
    idle(2);

    // Flush drops both the held result and the input offered alongside it.
    out_ready_i = 1'b0;
    issue(16'h3C00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h4000, 5'h00);
    flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1;
    @(negedge clk_i);
    chk("flush_in_ready", 32'(in_ready_o), 32'd1);
    sb.delete();
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);
    idle(1);
    chk("flush_drop", 32'(out_valid_o), 32'd0);

    // Reset with a result held.
    out_ready_i = 1'b0;
    tag_ctr = 1;
    issue(16'h3C00, 16'h3C00, 1'b0, RNE, ADD, FP16, 16'h4000, 5'h00);
    rst_ni = 1'b0;
    idle(1);
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_tag", 32'(tag_o), 32'd0);
    sb.delete();
    rst_ni = 1'b1; out_ready_i = 1'b1;
    idle(1);

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      if (&ra[14:10]) ra[14] = 1'b0;
      rb = 16'($urandom);
      if (&rb[14:10]) rb[14] = 1'b0;
      rm_d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rb   = ra ^ 16'($urandom_range(0, 7));
        rm_d = 1'b1;
      end
      rr   = 3'($urandom_range(0, 4));
      mexp = model(ra, rb, rm_d, rr);
      issue(ra, rb, rm_d, rr, ADD, FP16, mexp[15:0], mexp[20:16]);
    end
    rdy_rand = 1'b0;
    out_ready_i = 1'b1;
    idle(4);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
